// File: rtl/combo_lock_pkg.sv
// Shared definitions for the combination lock.
//   - state_e  : FSM state encoding (StLockout only exists with COMBO_LOCK_LOCKOUT_EN)
//   - DigitW   : width of one key index / code digit
//   - NumDigits: digits per code entry
//   - NumKeys  : number of physical keys (one pulse bit each)
//   - TimerW   : width of the shared down-counter
// Optional feature macro: COMBO_LOCK_LOCKOUT_EN.
package combo_lock_pkg;

  localparam int unsigned DigitW    = 2;
  localparam int unsigned NumDigits = 4;
  localparam int unsigned NumKeys   = 1 << DigitW;
  localparam int unsigned TimerW    = 16;

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StOpen,
`ifdef COMBO_LOCK_LOCKOUT_EN
    StLockout,
`endif
    StFail
  } state_e;

  // Digit n of the code lives at code[2n+1:2n]; digit 0 is entered first.
  function automatic logic [DigitW-1:0] code_digit(input logic [DigitW*NumDigits-1:0] code,
                                                   input logic [DigitW-1:0]           idx);
    return code[int'(idx)*DigitW +: DigitW];
  endfunction

  // A key matches only if it is exactly the one-hot pulse of that digit; multi-hot never matches.
  function automatic logic key_hit(input logic [NumKeys-1:0] key,
                                   input logic [DigitW-1:0]  digit);
    logic [NumKeys-1:0] onehot;
    onehot        = '0;
    onehot[digit] = 1'b1;
    return key == onehot;
  endfunction

endpackage

// File: rtl/combo_lock_timer.sv
// Loadable down-counter shared by entry timeout, open hold and lockout hold.
//   clk_i, rst_ni : clock, async active-low reset (count clears to 0)
//   load_i        : load value_i this cycle (wins over counting)
//   value_i       : value to load
//   expired_o     : count has reached 0 (counter then holds at 0)
module combo_lock_timer
  import combo_lock_pkg::*;
#(
  parameter int unsigned Width = TimerW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] value_i,
  output logic             expired_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = value_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/combo_lock_fsm.sv
// Four-digit combination lock with entry timeout, timed open and optional lockout.
//   Clock          : clock, all state changes on rising edge
//   Resetn         : async active-low reset
//   key_pulse      : one-cycle key pulses, one bit per key
//   lock_pulse     : one-cycle relock / abort request
//   unlock         : lock open (OPEN_CYCLES cycles after a correct code)
//   error          : one-cycle pulse on a failed entry
//   locked_out     : lockout active (tied 0 without COMBO_LOCK_LOCKOUT_EN)
//   digits_entered : keys accepted in the current entry (0 outside entry)
//   fail_cnt       : consecutive failures, saturating at MAX_FAILS
// Optional feature macro: COMBO_LOCK_LOCKOUT_EN enables the lockout state.
module combo_lock_fsm
  import combo_lock_pkg::*;
#(
  parameter logic [DigitW*NumDigits-1:0] CODE           = 8'h1B,
  parameter int unsigned                 OPEN_CYCLES    = 8,
  parameter int unsigned                 ENTRY_TIMEOUT  = 16,
  parameter int unsigned                 MAX_FAILS      = 3,
  parameter int unsigned                 LOCKOUT_CYCLES = 32
) (
  input  logic               Clock,
  input  logic               Resetn,
  input  logic [NumKeys-1:0] key_pulse,
  input  logic               lock_pulse,
  output logic               unlock,
  output logic               error,
  output logic               locked_out,
  output logic [2:0]         digits_entered,
  output logic [1:0]         fail_cnt
);

  // Timer loads are N-1: the counter spends N cycles counting down to and including 0.
  localparam logic [TimerW-1:0] EntryLoad = TimerW'(ENTRY_TIMEOUT - 1);
  localparam logic [TimerW-1:0] OpenLoad  = TimerW'(OPEN_CYCLES - 1);
  localparam logic [1:0]        MaxFails  = 2'(MAX_FAILS);

  state_e            state_d, state_q;
  logic [2:0]        digits_d, digits_q;
  logic              mism_d, mism_q;
  logic [1:0]        fail_d, fail_q;
  logic              tmr_load, tmr_expired;
  logic [TimerW-1:0] tmr_value;
  logic              key_ev, miss;

  assign key_ev = |key_pulse;

  combo_lock_timer #(
    .Width(TimerW)
  ) u_timer (
    .clk_i    (Clock),
    .rst_ni   (Resetn),
    .load_i   (tmr_load),
    .value_i  (tmr_value),
    .expired_o(tmr_expired)
  );

  always_comb begin
    state_d   = state_q;
    digits_d  = digits_q;
    mism_d    = mism_q;
    fail_d    = fail_q;
    tmr_load  = 1'b0;
    tmr_value = '0;
    miss      = mism_q | ~key_hit(key_pulse, code_digit(CODE, digits_q[DigitW-1:0]));

    unique case (state_q)
      StIdle: begin
        // lock_pulse is ignored here but still swallows a same-cycle key.
        if (key_ev && !lock_pulse) begin
          state_d   = StEntry;
          digits_d  = 3'd1;
          mism_d    = ~key_hit(key_pulse, code_digit(CODE, '0));
          tmr_load  = 1'b1;
          tmr_value = EntryLoad;
        end
      end

      StEntry: begin
        if (lock_pulse) begin
          state_d  = StIdle;
          digits_d = '0;
          mism_d   = 1'b0;
        end else if (key_ev) begin
          if (digits_q == 3'(NumDigits - 1)) begin
            digits_d = '0;
            mism_d   = 1'b0;
            if (miss) begin
              state_d = StFail;
              if (fail_q < MaxFails) begin
                fail_d = fail_q + 2'd1;
              end
            end else begin
              state_d   = StOpen;
              fail_d    = '0;
              tmr_load  = 1'b1;
              tmr_value = OpenLoad;
            end
          end else begin
            digits_d  = digits_q + 3'd1;
            mism_d    = miss;
            tmr_load  = 1'b1;
            tmr_value = EntryLoad;
          end
        end else if (tmr_expired) begin
          state_d  = StIdle;
          digits_d = '0;
          mism_d   = 1'b0;
        end
      end

      StOpen: begin
        if (lock_pulse || tmr_expired) begin
          state_d = StIdle;
        end
      end

      StFail: begin
        state_d = StIdle;
`ifdef COMBO_LOCK_LOCKOUT_EN
        // fail_q already holds the incremented count.
        if (fail_q == MaxFails) begin
          state_d   = StLockout;
          tmr_load  = 1'b1;
          tmr_value = TimerW'(LOCKOUT_CYCLES - 1);
        end
`endif
      end

`ifdef COMBO_LOCK_LOCKOUT_EN
      StLockout: begin
        if (tmr_expired) begin
          state_d = StIdle;
          fail_d  = '0;
        end
      end
`endif

      default: begin
        state_d  = StIdle;
        digits_d = '0;
        mism_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= StIdle;
      digits_q <= '0;
      mism_q   <= 1'b0;
      fail_q   <= '0;
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      mism_q   <= mism_d;
      fail_q   <= fail_d;
    end
  end

  assign unlock         = (state_q == StOpen);
  assign error          = (state_q == StFail);
  assign digits_entered = (state_q == StEntry) ? digits_q : 3'd0;
  assign fail_cnt       = fail_q;

`ifdef COMBO_LOCK_LOCKOUT_EN
  assign locked_out = (state_q == StLockout);
`else
  assign locked_out = 1'b0;
  logic unused_lockout_cycles;
  assign unused_lockout_cycles = ^LOCKOUT_CYCLES;
`endif

endmodule

// File: tb/tb_combo_lock_fsm.sv
// Self-checking bench for combo_lock_fsm (default parameters, code 3,2,1,0).
// Output snapshot packing: {unlock, error, locked_out, digits_entered[2:0], fail_cnt[1:0]}.
// Honours COMBO_LOCK_LOCKOUT_EN for the lockout expectations.
module tb_combo_lock_fsm;

  logic       Clock = 1'b0;
  logic       Resetn;
  logic [3:0] key_pulse;
  logic       lock_pulse;
  logic       unlock, error, locked_out;
  logic [2:0] digits_entered;
  logic [1:0] fail_cnt;
  logic [7:0] outs;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] key;
    logic       lock;
    logic [7:0] exp;
  } step_t;

  step_t      seq[$];
  logic [7:0] sb[$];
  logic [7:0] exp_v;

  localparam logic [3:0] NK = 4'b0000;
  localparam logic [3:0] K0 = 4'b0001;
  localparam logic [3:0] K1 = 4'b0010;
  localparam logic [3:0] K2 = 4'b0100;
  localparam logic [3:0] K3 = 4'b1000;

  always #5 Clock = ~Clock;

  assign outs = {unlock, error, locked_out, digits_entered, fail_cnt};

  combo_lock_fsm dut (
    .Clock         (Clock),
    .Resetn        (Resetn),
    .key_pulse     (key_pulse),
    .lock_pulse    (lock_pulse),
    .unlock        (unlock),
    .error         (error),
    .locked_out    (locked_out),
    .digits_entered(digits_entered),
    .fail_cnt      (fail_cnt)
  );

  function automatic logic [7:0] ev(logic u, logic e, logic l, logic [2:0] d, logic [1:0] f);
    return {u, e, l, d, f};
  endfunction

  function automatic void add(logic [3:0] k, logic l, logic [7:0] e);
    seq.push_back('{key: k, lock: l, exp: e});
  endfunction

  function automatic void add_n(int n, logic [7:0] e);
    for (int i = 0; i < n; i++) add(NK, 1'b0, e);
  endfunction

  // Correct code, no gaps: open for 8 cycles then idle.
  function automatic void add_good(logic [1:0] f_before);
    add(K3, 1'b0, ev(0, 0, 0, 3'd1, f_before));
    add(K2, 1'b0, ev(0, 0, 0, 3'd2, f_before));
    add(K1, 1'b0, ev(0, 0, 0, 3'd3, f_before));
    add(K0, 1'b0, ev(1, 0, 0, 3'd0, 2'd0));
    add_n(7, ev(1, 0, 0, 3'd0, 2'd0));
    add_n(1, ev(0, 0, 0, 3'd0, 2'd0));
  endfunction

  // Entry 0,0,0,0 with fail_cnt f_before: error cycle shows f_after.
  function automatic void add_bad(logic [1:0] f_before, logic [1:0] f_after);
    add(K0, 1'b0, ev(0, 0, 0, 3'd1, f_before));
    add(K0, 1'b0, ev(0, 0, 0, 3'd2, f_before));
    add(K0, 1'b0, ev(0, 0, 0, 3'd3, f_before));
    add(K0, 1'b0, ev(0, 1, 0, 3'd0, f_after));
  endfunction

  task automatic test_reset;
    Resetn = 1'b1; key_pulse = '0; lock_pulse = 1'b0;
    #2 Resetn = 1'b0;
    sb.push_back(8'h00);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (outs !== exp_v) begin
      errors++; $display("FAIL reset outs=%b expected=%b", outs, exp_v);
    end
    @(negedge Clock) Resetn = 1'b1;
    @(posedge Clock); #1;
  endtask

  task automatic test_unlock;
    seq.delete();
    add(K3, 1'b0, ev(0, 0, 0, 3'd1, 2'd0)); add_n(2, ev(0, 0, 0, 3'd1, 2'd0));
    add(K2, 1'b0, ev(0, 0, 0, 3'd2, 2'd0)); add_n(2, ev(0, 0, 0, 3'd2, 2'd0));
    add(K1, 1'b0, ev(0, 0, 0, 3'd3, 2'd0)); add_n(2, ev(0, 0, 0, 3'd3, 2'd0));
    add(K0, 1'b0, ev(1, 0, 0, 3'd0, 2'd0));
    add_n(7, ev(1, 0, 0, 3'd0, 2'd0));
    add_n(2, ev(0, 0, 0, 3'd0, 2'd0));
    foreach (seq[i]) begin
      key_pulse = seq[i].key; lock_pulse = seq[i].lock; sb.push_back(seq[i].exp);
      @(posedge Clock); #1; key_pulse = '0; lock_pulse = 1'b0;
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL unlock step %0d outs=%b expected=%b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_wrong_code;
    seq.delete();
    add(K3, 1'b0, ev(0, 0, 0, 3'd1, 2'd0));
    add(K2, 1'b0, ev(0, 0, 0, 3'd2, 2'd0));
    add(K0, 1'b0, ev(0, 0, 0, 3'd3, 2'd0));
    add(K0, 1'b0, ev(0, 1, 0, 3'd0, 2'd1));
    add_n(2, ev(0, 0, 0, 3'd0, 2'd1));
    foreach (seq[i]) begin
      key_pulse = seq[i].key; lock_pulse = seq[i].lock; sb.push_back(seq[i].exp);
      @(posedge Clock); #1; key_pulse = '0; lock_pulse = 1'b0;
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL wrong_code step %0d outs=%b expected=%b", i, outs, exp_v);
      end
    end
  endtask

  // Enters with fail_cnt = 1 from the previous test.
  task automatic test_timeout;
    seq.delete();
    add(K3, 1'b0, ev(0, 0, 0, 3'd1, 2'd1));
    add(K2, 1'b0, ev(0, 0, 0, 3'd2, 2'd1));
    add_n(15, ev(0, 0, 0, 3'd2, 2'd1));
    add_n(2, ev(0, 0, 0, 3'd0, 2'd1));
    add_good(2'd1);
    foreach (seq[i]) begin
      key_pulse = seq[i].key; lock_pulse = seq[i].lock; sb.push_back(seq[i].exp);
      @(posedge Clock); #1; key_pulse = '0; lock_pulse = 1'b0;
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL timeout step %0d outs=%b expected=%b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_multihot_and_lock;
    seq.delete();
    add(4'b1001, 1'b0, ev(0, 0, 0, 3'd1, 2'd0));
    add(K2, 1'b0, ev(0, 0, 0, 3'd2, 2'd0));
    add(K1, 1'b0, ev(0, 0, 0, 3'd3, 2'd0));
    add(K0, 1'b0, ev(0, 1, 0, 3'd0, 2'd1));
    add_n(1, ev(0, 0, 0, 3'd0, 2'd1));
    add(K3, 1'b0, ev(0, 0, 0, 3'd1, 2'd1));
    add(K2, 1'b0, ev(0, 0, 0, 3'd2, 2'd1));
    add(K1, 1'b0, ev(0, 0, 0, 3'd3, 2'd1));
    add(K0, 1'b0, ev(1, 0, 0, 3'd0, 2'd0));
    add_n(2, ev(1, 0, 0, 3'd0, 2'd0));
    add(NK, 1'b1, ev(0, 0, 0, 3'd0, 2'd0));  // relock during open
    add(K3, 1'b1, ev(0, 0, 0, 3'd0, 2'd0));  // key dropped in idle
    add(K3, 1'b0, ev(0, 0, 0, 3'd1, 2'd0));
    add(K2, 1'b0, ev(0, 0, 0, 3'd2, 2'd0));
    add(K1, 1'b1, ev(0, 0, 0, 3'd0, 2'd0));  // abort beats same-cycle key
    add_n(1, ev(0, 0, 0, 3'd0, 2'd0));
    foreach (seq[i]) begin
      key_pulse = seq[i].key; lock_pulse = seq[i].lock; sb.push_back(seq[i].exp);
      @(posedge Clock); #1; key_pulse = '0; lock_pulse = 1'b0;
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL multihot_lock step %0d outs=%b expected=%b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_lockout;
    seq.delete();
    add_bad(2'd0, 2'd1); add_n(1, ev(0, 0, 0, 3'd0, 2'd1));
    add_bad(2'd1, 2'd2); add_n(1, ev(0, 0, 0, 3'd0, 2'd2));
    add_bad(2'd2, 2'd3);
`ifdef COMBO_LOCK_LOCKOUT_EN
    add_n(1, ev(0, 0, 1, 3'd0, 2'd3));
    for (int i = 0; i < 31; i++) begin
      add(4'b0001 << (3 - (i % 4)), 1'b0, ev(0, 0, 1, 3'd0, 2'd3));
    end
    add(K3, 1'b0, ev(0, 0, 0, 3'd0, 2'd0));  // last lockout cycle still drops keys
    add_n(1, ev(0, 0, 0, 3'd0, 2'd0));
    add_good(2'd0);
`else
    add_n(1, ev(0, 0, 0, 3'd0, 2'd3));
    add_bad(2'd3, 2'd3);
    add_n(32, ev(0, 0, 0, 3'd0, 2'd3));
    add_good(2'd3);
`endif
    foreach (seq[i]) begin
      key_pulse = seq[i].key; lock_pulse = seq[i].lock; sb.push_back(seq[i].exp);
      @(posedge Clock); #1; key_pulse = '0; lock_pulse = 1'b0;
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL lockout step %0d outs=%b expected=%b", i, outs, exp_v);
      end
    end
  endtask

  task automatic test_async_reset;
    // Mid-entry, with a nonzero fail count.
    seq.delete();
    add_bad(2'd0, 2'd1); add_n(1, ev(0, 0, 0, 3'd0, 2'd1));
    add(K3, 1'b0, ev(0, 0, 0, 3'd1, 2'd1));
    add(K2, 1'b0, ev(0, 0, 0, 3'd2, 2'd1));
    foreach (seq[i]) begin
      key_pulse = seq[i].key; lock_pulse = seq[i].lock; sb.push_back(seq[i].exp);
      @(posedge Clock); #1; key_pulse = '0; lock_pulse = 1'b0;
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL rst_entry_pre step %0d outs=%b expected=%b", i, outs, exp_v);
      end
    end
    #2 Resetn = 1'b0;
    sb.push_back(8'h00);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (outs !== exp_v) begin
      errors++; $display("FAIL rst_mid_entry outs=%b expected=%b", outs, exp_v);
    end
    @(negedge Clock) Resetn = 1'b1;
    @(posedge Clock); #1;

    // Mid-lockout (or saturated failures without the lockout feature).
    seq.delete();
    add_bad(2'd0, 2'd1); add_n(1, ev(0, 0, 0, 3'd0, 2'd1));
    add_bad(2'd1, 2'd2); add_n(1, ev(0, 0, 0, 3'd0, 2'd2));
    add_bad(2'd2, 2'd3);
`ifdef COMBO_LOCK_LOCKOUT_EN
    add_n(4, ev(0, 0, 1, 3'd0, 2'd3));
`else
    add_n(4, ev(0, 0, 0, 3'd0, 2'd3));
`endif
    foreach (seq[i]) begin
      key_pulse = seq[i].key; lock_pulse = seq[i].lock; sb.push_back(seq[i].exp);
      @(posedge Clock); #1; key_pulse = '0; lock_pulse = 1'b0;
      exp_v = sb.pop_front(); checks++;
      if (outs !== exp_v) begin
        errors++; $display("FAIL rst_lock_pre step %0d outs=%b expected=%b", i, outs, exp_v);
      end
    end
    #2 Resetn = 1'b0;
    sb.push_back(8'h00);
    #1;
    exp_v = sb.pop_front(); checks++;
    if (outs !== exp_v) begin
      errors++; $display("FAIL rst_mid_lockout outs=%b expected=%b", outs, exp_v);
    end
    @(negedge Clock) Resetn = 1'b1;
    @(posedge Clock); #1;
  endtask

  initial begin
    test_reset();
    test_unlock();
    test_wrong_code();
    test_timeout();
    test_multihot_and_lock();
    test_lockout();
    test_async_reset();
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain left=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
